// File: rtl/sprite_line_writer_pkg.sv
// Shared video definitions: line-buffer byte layout, render FSM encodings and
// the captured sprite-request record.
package sprite_line_writer_pkg;

    localparam int LINE_LEN_DEFAULT = 352;

    localparam int LB_OCC    = 7;
    localparam int LB_PRIO   = 6;
    localparam int LB_PAL_HI = 5;
    localparam int LB_PAL_LO = 4;
    localparam int LB_COL_HI = 3;
    localparam int LB_COL_LO = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RD    = 2'd2;
    localparam logic [1:0] ST_WR    = 2'd3;

    typedef struct packed {
        logic [8:0]  x;
        logic [31:0] pattern;
        logic [1:0]  palette;
        logic        hflip;
        logic        prio;
    } sprite_req_t;

    // Pixel 0 sits in the top nibble; hflip walks the word from the other end.
    function automatic logic [3:0] pick_nibble(input logic [31:0] pat,
                                               input logic [2:0]  n,
                                               input logic        hflip);
        logic [2:0] k;
        k = hflip ? n : (3'd7 - n);
        return pat[{k, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/sprite_line_writer_if.sv
// Sprite request handshake, clear request and line-buffer render port.
interface sprite_line_writer_if;
    logic        clear_req;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_x;
    logic [31:0] req_pattern;
    logic [1:0]  req_palette;
    logic        req_hflip;
    logic        req_priority;
    logic        busy;
    logic [8:0]  lb_idx;
    logic [7:0]  lb_wrdata;
    logic        lb_wren;
    logic [7:0]  lb_rddata;

    // master: sprite fetch plus the line buffer itself; slave: the writer
    modport master (
        output clear_req, req_valid, req_x, req_pattern, req_palette,
               req_hflip, req_priority, lb_rddata,
        input  req_ready, busy, lb_idx, lb_wrdata, lb_wren
    );

    modport slave (
        input  clear_req, req_valid, req_x, req_pattern, req_palette,
               req_hflip, req_priority, lb_rddata,
        output req_ready, busy, lb_idx, lb_wrdata, lb_wren
    );
endinterface

// File: rtl/sprite_line_writer.sv
// Writes 8-pixel sprite words into the render half of the line buffer with a
// per-pixel read-modify-write (first sprite wins, tile priority honoured); also clears it.
module sprite_line_writer
    import sprite_line_writer_pkg::*;
#(
    parameter int LINE_LEN = LINE_LEN_DEFAULT
) (
    input logic                 clk,
    input logic                 reset_n,
    sprite_line_writer_if.slave bus
);

    localparam logic [9:0] LEN_W    = 10'(LINE_LEN);
    localparam logic [8:0] LAST_IDX = 9'(LINE_LEN - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  n_q, n_d;
    logic [8:0]  idx_q, idx_d;
    sprite_req_t req_q, req_d;

    logic [3:0]  colour;
    logic        in_range;
    logic        slot_free;
    logic [7:0]  wrdata;
    logic        wren;

    // lb_rddata in WR is the byte read at the same index during the preceding RD
    always_comb begin
        colour    = pick_nibble(req_q.pattern, n_q, req_q.hflip);
        in_range  = {1'b0, idx_q} < LEN_W;
        slot_free = !bus.lb_rddata[LB_OCC] && (req_q.prio || !bus.lb_rddata[LB_PRIO]);
        wrdata    = 8'h00;
        wren      = 1'b0;
        case (state_q)
            ST_CLEAR: wren = 1'b1;
            ST_WR: begin
                if ((colour != 4'h0) && in_range && slot_free) begin
                    wren                        = 1'b1;
                    wrdata[LB_OCC]              = 1'b1;
                    wrdata[LB_PRIO]             = req_q.prio;
                    wrdata[LB_PAL_HI:LB_PAL_LO] = req_q.palette;
                    wrdata[LB_COL_HI:LB_COL_LO] = colour;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = 9'd0;
                end else if (bus.req_valid) begin
                    state_d = ST_RD;
                    n_d     = 3'd0;
                    idx_d   = bus.req_x;
                    req_d   = '{x:       bus.req_x,
                                pattern: bus.req_pattern,
                                palette: bus.req_palette,
                                hflip:   bus.req_hflip,
                                prio:    bus.req_priority};
                end
            end
            ST_CLEAR: begin
                if (idx_q == LAST_IDX) state_d = ST_IDLE;
                else                   idx_d   = idx_q + 9'd1;
            end
            ST_RD: state_d = ST_WR;
            ST_WR: begin
                if (n_q == 3'd7) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD;
                    n_d     = n_q + 3'd1;
                    idx_d   = idx_q + 9'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            n_q     <= 3'd0;
            idx_q   <= 9'd0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            req_q   <= req_d;
        end
    end

    assign bus.lb_idx    = idx_q;
    assign bus.lb_wrdata = wrdata;
    assign bus.lb_wren   = wren;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.req_ready = (state_q == ST_IDLE) && !bus.clear_req;

endmodule

// File: doc/sprite_line_writer.md
# sprite_line_writer

Render-side writer for the double-buffered video line buffer. It accepts 8-pixel, 4-bpp sprite pattern words during horizontal time and writes them into the line-buffer half currently selected for rendering, using a read-modify-write per pixel to enforce first-sprite-wins and sprite/tile priority. It also clears that half on request. It drives the buffer's read/write render port; the display scan-out reads the other half.

## Interface
- LINE_LEN, 352: number of valid line-buffer entries (≤512); indices ≥ LINE_LEN are never written.
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  single-cycle request to zero entries 0..LINE_LEN-1.
- req_valid  in  1  sprite word request valid.
- req_ready  out  1  high only in IDLE with clear_req low; transfer on req_valid && req_ready.
- req_x  in  9  buffer index of the leftmost displayed pixel.
- req_pattern  in  32  8 pixels × 4 bits; pixel 0 in [31:28], pixel 7 in [3:0].
- req_palette  in  2  sprite palette select.
- req_hflip  in  1  reverse pixel order.
- req_priority  in  1  sprite drawn over priority tiles.
- busy  out  1  state != IDLE.
- lb_idx  out  9  render-port index (registered).
- lb_wrdata  out  8  render-port write data.
- lb_wren  out  1  render-port write enable.
- lb_rddata  in  8  render-port read data; one cycle read latency, write-first.

## Operation
- Buffer byte format: [7] sprite-occupied, [6] priority, [5:4] palette, [3:0] colour. Bits [5:0] feed the palette lookup.
- States: IDLE, CLEAR, RD, WR.
- IDLE + clear_req → CLEAR. clear_req wins over a simultaneous req_valid, and req_ready is low that cycle. clear_req outside IDLE is ignored.
- IDLE + accepted request → RD with pixel counter n=0. All req_* fields are captured on acceptance.
- RD → WR → RD for n=0..7. After WR of n=7 → IDLE.
- CLEAR steps lb_idx 0..LINE_LEN-1 with lb_wren=1 and lb_wrdata=8'h00, then → IDLE.
- Pixel n uses pattern nibble n, or nibble 7-n when hflip=1.
- Pixel n targets index (req_x + n) mod 512 (9-bit wrap).
- lb_wren in WR is 1 only when all of the following hold:
  - colour != 0 (transparent pixels are skipped);
  - target index < LINE_LEN;
  - lb_rddata[7]=0 (an earlier sprite wins);
  - req_priority=1 or lb_rddata[6]=0.
- Write data is {1'b1, req_priority, req_palette, colour}.
- lb_wrdata and lb_wren are combinational from state, captured fields and lb_rddata. They are 0 in IDLE, RD and skipped WR cycles.

## Timing
- Reset (asynchronous assert): state IDLE, lb_idx=0, lb_wren=0, lb_wrdata=0, busy=0. req_ready=1 from the first cycle after deassertion.
- Sprite word accepted in cycle c0:
  - lb_idx = target of pixel n in cycles c(2n+1) (read) and c(2n+2) (write).
  - Last possible write in c16; busy=1 in c1..c16; req_ready=1 again in c17.
  - Throughput is one word per 17 cycles.
- Clear accepted in c0: writes in c1..c(LINE_LEN); IDLE in c(LINE_LEN+1).
- Each pixel writes in the cycle after its own read, so within one word, overlapping indices (possible only via wrap) see earlier pixels' writes.
- Asynchronous reset mid-word or mid-clear aborts immediately, with no further writes. Buffer contents are whatever was already written.

## Structure
- Shared video package holds:
  - bit-position constants LB_OCC=7 and LB_PRIO=6;
  - palette field [5:4] and colour field [3:0];
  - the state enum;
  - the LINE_LEN default.
- No sub-module: nibble select, index add and priority compare are inline combinational logic around a single FSM.

## Test plan
- Reset release, clear_req pulse with LINE_LEN=352 → 352 consecutive writes of 8'h00 at idx 0..351, busy low in the next cycle.
- Empty buffer, req_x=10, pattern=32'h12345678, palette=2, hflip=0, priority=0 → idx 10..17 hold 8'hA1..8'hA8; req_ready returns 17 cycles after acceptance.
- Same request with hflip=1 → idx 10 holds 8'hA8, idx 17 holds 8'hA1.
- Pattern 32'h10203040 → only idx x, x+2, x+4, x+6 are written; lb_wren=0 on the other four WR cycles.
- Pre-load idx 20 = 8'h85 (occupied) and idx 21 = 8'h45 (priority tile); write a sprite covering idx 20..21:
  - with priority=0 → both unchanged;
  - with priority=1 → idx 20 unchanged, idx 21 overwritten.
- req_x=508 → writes at idx 508..511 and 0..3; req_x=348 with LINE_LEN=352 → only idx 348..351 written. Then assert reset_n low mid-word → lb_wren drops immediately and no further writes occur.
